uart_bus_master: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_byte.sv | 86 ++++++++
 rtl/uart_bus_master.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and command FSM state type for the UART bus master.
package uart_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 1250;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } cmd_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchroniser, start-bit glitch rejection, mid-bit sampling, stop check.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 1250
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o
);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [15:0] TICK_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] TICK_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]  sync_q;
    logic        rx_prev_q;
    logic [1:0]  state_q;
    logic [15:0] tick_q;
    logic [3:0]  bit_q;
    logic        rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            state_q     <= RX_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            byte_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], rx_i};
            rx_prev_q   <= rx_s;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q <= RX_START;
                        tick_q  <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (tick_q == TICK_HALF) begin
                        tick_q  <= '0;
                        bit_q   <= '0;
                        state_q <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        byte_o <= {rx_s, byte_o[7:1]};
                        bit_q  <= bit_q + 4'd1;
                        if (bit_q == 4'd7) state_q <= RX_STOP;
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end
                default: begin
                    if (tick_q == TICK_LAST) begin
                        tick_q      <= '0;
                        state_q     <= RX_IDLE;
                        valid_o     <= rx_s;
                        frame_err_o <= !rx_s;
                    end else begin
                        tick_q <= tick_q + 16'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// UART command bridge: 'W'/'R' + address (+ data) frames become req/gnt bus transfers.
module uart_bus_master import uart_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        uart_rx_i,
    output logic        uart_tx_o,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    output logic        busy_o
);

    localparam logic [15:0] TICK_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ferr;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (uart_rx_i),
        .byte_o      (rx_byte),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    logic        tx_busy_q;
    logic [9:0]  tx_frame_q;
    logic [15:0] tx_tick_q;
    logic [3:0]  tx_bit_q;
    logic        tx_start, tx_done, tx_free;
    logic [7:0]  tx_byte;

    // The stop bit's last cycle also counts as free so frames go out back-to-back.
    assign tx_done = tx_busy_q && (tx_tick_q == TICK_LAST) && (tx_bit_q == 4'd9);
    assign tx_free = !tx_busy_q || tx_done;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_busy_q  <= 1'b0;
            tx_frame_q <= '1;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            uart_tx_o  <= 1'b1;
        end else if (tx_start) begin
            tx_busy_q  <= 1'b1;
            tx_frame_q <= {1'b1, tx_byte, 1'b0};
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            uart_tx_o  <= 1'b0;
        end else if (tx_busy_q) begin
            if (tx_tick_q == TICK_LAST) begin
                tx_tick_q <= '0;
                if (tx_bit_q == 4'd9) begin
                    tx_busy_q <= 1'b0;
                    tx_bit_q  <= '0;
                    uart_tx_o <= 1'b1;
                end else begin
                    tx_bit_q   <= tx_bit_q + 4'd1;
                    tx_frame_q <= tx_frame_q >> 1;
                    uart_tx_o  <= tx_frame_q[1];
                end
            end else begin
                tx_tick_q <= tx_tick_q + 16'd1;
            end
        end
    end

    cmd_state_e  state_q;
    logic [1:0]  byte_cnt_q;
    logic [2:0]  rsp_cnt_q;
    logic        nak_q;
    logic [31:0] rdata_q;
    logic [31:0] to_cnt_q;
    logic [2:0]  rsp_len;

    assign rsp_len  = (nak_q || bus_we_o) ? 3'd1 : 3'd4;
    assign tx_start = (state_q == ST_RESP) && tx_free && (rsp_cnt_q != rsp_len);
    assign tx_byte  = nak_q ? RSP_NAK : (bus_we_o ? RSP_ACK : rdata_q[31:24]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            byte_cnt_q  <= '0;
            rsp_cnt_q   <= '0;
            nak_q       <= 1'b0;
            rdata_q     <= '0;
            to_cnt_q    <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        busy_o     <= 1'b1;
                        to_cnt_q   <= '0;
                        byte_cnt_q <= '0;
                        rsp_cnt_q  <= '0;
                        if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                            bus_we_o <= (rx_byte == CMD_WRITE);
                            nak_q    <= 1'b0;
                            state_q  <= ST_ADDR;
                        end else begin
                            nak_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end
                    end
                end
                ST_ADDR, ST_DATA: begin
                    if (rx_ferr) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end else if (rx_valid) begin
                        to_cnt_q   <= '0;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (state_q == ST_ADDR) bus_addr_o  <= {bus_addr_o[23:0], rx_byte};
                        else                    bus_wdata_o <= {bus_wdata_o[23:0], rx_byte};
                        if (byte_cnt_q == 2'd3) begin
                            if (state_q == ST_ADDR && bus_we_o) begin
                                state_q <= ST_DATA;
                            end else begin
                                state_q   <= ST_BUS;
                                bus_req_o <= 1'b1;
                            end
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
                    end
                end
                ST_BUS: begin
                    if (bus_gnt_i) begin
                        bus_req_o <= 1'b0;
                        if (!bus_we_o) rdata_q <= bus_rdata_i;
                        rsp_cnt_q <= '0;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (tx_start) begin
                        rsp_cnt_q <= rsp_cnt_q + 3'd1;
                        rdata_q   <= rdata_q << 8;
                    end else if (rsp_cnt_q == rsp_len && tx_done) begin
                        state_q <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
